mem_arbiter: RTL

//  Two-requester memory arbiter between the icache and the dcache (cache-control side) and the single-ported RAM.
//  It grants one requester at a time and latches that request's address and data.
//  It drives the RAM strobes and returns per-requester wait/load with the cache-control handshake (wait low = done).
//  The dcache has priority; a starvation counter guarantees instruction fetch progress.

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter between icache and dcache and one single-ported RAM.
// The dcache has priority. A saturating starvation counter makes sure instruction fetch still progresses.
// A granted request's address, data and op are latched for the whole access.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              CLK,
    input  logic              RST,
    // icache side
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [ADDR_W-1:0] iload,
    // dcache side
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic              dwait,
    output logic [ADDR_W-1:0] dload,
    // RAM side
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    typedef logic [ADDR_W-1:0] word_t;
    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
    typedef enum logic [1:0] {IDLE = 2'd0, IGRANT = 2'd1, DGRANT = 2'd2} state_t;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t STARVE_MAX = cnt_t'(STARVE_LIMIT);

    state_t    state, nextState;
    word_t     latchedAddr, nextAddr;
    word_t     latchedStore, nextStore;
    logic      latchedWrite, nextWrite;
    cnt_t      starveCnt, nextCnt;
    ramstate_t ramState;
    logic      dReq;
    logic      iStarved;

    assign ramState = ramstate_t'(ramstate);
    // A simultaneous dREN and dWEN counts as one request. It is treated as a write.
    assign dReq     = dREN | dWEN;
    // The icache wins the next arbitration once the dcache has taken STARVE_LIMIT grants in a row while iREN waited.
    assign iStarved = iREN && (starveCnt >= STARVE_MAX);

    // The RAM always sees the latched request. Changes on the requester side during a grant are ignored.
    assign ramaddr  = latchedAddr;
    assign ramstore = latchedStore;

    // Register the state, the latched request and the starvation counter. Reset drops any in-flight access.
    // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            latchedAddr  <= '0;
            latchedStore <= '0;
            latchedWrite <= 1'b0;
            starveCnt    <= '0;
        end else begin
            state        <= nextState;
            latchedAddr  <= nextAddr;
            latchedStore <= nextStore;
            latchedWrite <= nextWrite;
            starveCnt    <= nextCnt;
        end
    end

    // Arbitrate in IDLE, and drive the RAM strobes and the granted requester's wait/load in a grant state.
    // NOTE: every signal written here is given a default first, so no path can infer a latch.
    always_comb begin
        nextState = state;
        nextAddr  = latchedAddr;
        nextStore = latchedStore;
        nextWrite = latchedWrite;
        nextCnt   = starveCnt;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        iwait     = 1'b1;
        dwait     = 1'b1;
        iload     = '0;
        dload     = '0;

        case (state)
            IDLE: begin
                if (!iREN) begin
                    nextCnt = '0;
                end
                if (dReq && !iStarved) begin
                    nextState = DGRANT;
                    nextAddr  = daddr;
                    nextStore = dstore;
                    nextWrite = dWEN;
                    if (iREN && (starveCnt < STARVE_MAX)) begin
                        nextCnt = starveCnt + cnt_t'(1);
                    end
                end else if (iREN) begin
                    nextState = IGRANT;
                    nextAddr  = iaddr;
                    nextWrite = 1'b0;
                    nextCnt   = '0;
                end
            end

            IGRANT: begin
                if (!iREN) begin
                    // The requester withdrew, so abort with no wait pulse.
                    nextState = IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (ramState == ACCESS) begin
                        iwait     = 1'b0;
                        iload     = ramload;
                        nextState = IDLE;
                    end
                end
            end

            DGRANT: begin
                if (!dReq) begin
                    nextState = IDLE;
                end else begin
                    ramWEN = latchedWrite;
                    ramREN = !latchedWrite;
                    // On FREE, BUSY and ERROR the strobe stays high, so the RAM keeps retrying.
                    if (ramState == ACCESS) begin
                        dwait     = 1'b0;
                        dload     = latchedWrite ? '0 : ramload;
                        nextState = IDLE;
                    end
                end
            end

            default: nextState = IDLE;
        endcase
    end

endmodule
